// File: rtl/fport_reader.sv
// Debounced input port: synchronises a WIDTH-bit pin bus, accepts a new value once it is held
// stable, and offers it to a consumer with a valid/ready event. Define FPORT_EDGE_EN to add rise/fall outputs.
module fport_reader #(
    parameter int WIDTH           = 5,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 12000
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] pins_in,
    output logic [WIDTH-1:0] data,
    output logic             changed,
    output logic [WIDTH-1:0] ev_data,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic             overflow
`ifdef FPORT_EDGE_EN
    ,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
`endif
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain;
    logic [WIDTH-1:0]                  sync;
    logic [WIDTH-1:0]                  sync_q;
    logic [CW-1:0]                     cnt;
    logic [CW-1:0]                     cnt_nxt;
    logic                              upd;

    assign sync = chain[SYNC_STAGES-1];

    // The first cycle a new value shows up at sync already counts towards the
    // stability window, so a clean step lands SYNC_STAGES + DEBOUNCE_CYCLES after the pin edge.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch is inferred.
        upd     = 1'b0;
        cnt_nxt = '0;
        if (sync != data) begin
            if (sync != sync_q) begin
                if (DEBOUNCE_CYCLES == 1) upd = 1'b1;
                else                      cnt_nxt = CW'(1);
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                upd = 1'b1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            chain    <= '0;
            sync_q   <= '0;
            cnt      <= '0;
            data     <= '0;
            changed  <= 1'b0;
            ev_data  <= '0;
            ev_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            chain   <= {chain[SYNC_STAGES-2:0], pins_in};
            sync_q  <= sync;
            cnt     <= cnt_nxt;
            changed <= upd;
            if (upd) begin
                data     <= sync;
                ev_data  <= sync;
                ev_valid <= 1'b1;
                // An unconsumed event is being replaced by a newer one.
                if (ev_valid && !ev_ready) overflow <= 1'b1;
            end else if (ev_valid && ev_ready) begin
                ev_valid <= 1'b0;
            end
        end
    end

`ifdef FPORT_EDGE_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rise <= '0;
            fall <= '0;
        end else begin
            rise <= upd ? (sync & ~data) : '0;
            fall <= upd ? (~sync & data) : '0;
        end
    end
`endif

endmodule
